// File: rtl/axi_lsu_ctrl_if.sv
// AXI4-Lite master-side bus bundle for the external load/store sequencer.
// Data width is fixed at 32 bits; only the address width is a parameter.
interface axi_lsu_ctrl_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 32
);
  logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [2:0]                m_axi_awprot;
  logic                      m_axi_awvalid;
  logic                      m_axi_awready;
  logic [31:0]               m_axi_wdata;
  logic [3:0]                m_axi_wstrb;
  logic                      m_axi_wvalid;
  logic                      m_axi_wready;
  logic [1:0]                m_axi_bresp;
  logic                      m_axi_bvalid;
  logic                      m_axi_bready;
  logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr;
  logic [2:0]                m_axi_arprot;
  logic                      m_axi_arvalid;
  logic                      m_axi_arready;
  logic [31:0]               m_axi_rdata;
  logic [1:0]                m_axi_rresp;
  logic                      m_axi_rvalid;
  logic                      m_axi_rready;

  modport master (
    output m_axi_awaddr, m_axi_awprot, m_axi_awvalid, input m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid, input m_axi_wready,
    input m_axi_bresp, m_axi_bvalid, output m_axi_bready,
    output m_axi_araddr, m_axi_arprot, m_axi_arvalid, input m_axi_arready,
    input m_axi_rdata, m_axi_rresp, m_axi_rvalid, output m_axi_rready
  );

  modport slave (
    input m_axi_awaddr, m_axi_awprot, m_axi_awvalid, output m_axi_awready,
    input m_axi_wdata, m_axi_wstrb, m_axi_wvalid, output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid, input m_axi_bready,
    input m_axi_araddr, m_axi_arprot, m_axi_arvalid, output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid, input m_axi_rready
  );
endinterface

// File: rtl/axi_lsu_ctrl.sv
// Runs one AXI4-Lite transaction per external load/store, stalling the pipeline
// until it completes and writing load results back in the one-cycle DONE state.
module axi_lsu_ctrl #(
  parameter int unsigned AXI_ADDR_WIDTH = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        axi_init_i,
  input  logic [31:0] axi_addr_i,
  input  logic [31:0] axi_data_w_i,
  input  logic        axi_mem_we_i,
  input  logic [2:0]  axi_funct3_i,
  input  logic [4:0]  addr_d_i,
  output logic        stall_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_addr_d_o,
  output logic [31:0] wb_data_o,
  output logic        err_o,
  axi_lsu_ctrl_if.master axi
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WRESP, S_RADDR, S_RDATA, S_DONE} state_e;

  state_e                    state_q, state_d;
  logic [1:0]                addr_lo_q, addr_lo_d;
  logic [2:0]                funct3_q, funct3_d;
  logic [4:0]                rd_q, rd_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [31:0]               wdata_q, wdata_d, wb_data_q, wb_data_d;
  logic [3:0]                wstrb_q, wstrb_d;
  logic                      awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                      arvalid_q, arvalid_d, rready_q, rready_d;
  logic                      wb_we_q, wb_we_d, err_q, err_d;
  logic [4:0]                wb_addr_q, wb_addr_d;

  logic                      illegal;
  logic [3:0]                lane_strb;
  logic [31:0]               lane_data, rshift, ld_ext;
  logic [AXI_ADDR_WIDTH-1:0] bus_addr;

  // Request decode: legality, word-aligned bus address and store lane placement.
  always_comb begin
    illegal = axi_mem_we_i ? !(axi_funct3_i inside {3'b000, 3'b001, 3'b010})
                           : !(axi_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    if ((axi_funct3_i[1:0] == 2'b01) && axi_addr_i[0])           illegal = 1'b1;
    if ((axi_funct3_i[1:0] == 2'b10) && (axi_addr_i[1:0] != 2'b00)) illegal = 1'b1;
    bus_addr = AXI_ADDR_WIDTH'({axi_addr_i[31:2], 2'b00});
    case (axi_funct3_i[1:0])
      2'b00: begin
        lane_strb = 4'b0001 << axi_addr_i[1:0];
        lane_data = {4{axi_data_w_i[7:0]}};
      end
      2'b01: begin
        lane_strb = 4'b0011 << {axi_addr_i[1], 1'b0};
        lane_data = {2{axi_data_w_i[15:0]}};
      end
      default: begin
        lane_strb = 4'b1111;
        lane_data = axi_data_w_i;
      end
    endcase
  end

  // Load extraction: shifting by the byte offset aligns both byte and half lanes.
  always_comb begin
    rshift = axi.m_axi_rdata >> {addr_lo_q, 3'b000};
    case (funct3_q)
      3'b000:  ld_ext = {{24{rshift[7]}}, rshift[7:0]};
      3'b100:  ld_ext = {24'h0, rshift[7:0]};
      3'b001:  ld_ext = {{16{rshift[15]}}, rshift[15:0]};
      3'b101:  ld_ext = {16'h0, rshift[15:0]};
      default: ld_ext = axi.m_axi_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_lo_d = addr_lo_q;
    funct3_d  = funct3_q;
    rd_d      = rd_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    wb_we_d   = 1'b0;
    err_d     = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    case (state_q)
      S_IDLE: begin
        if (axi_init_i) begin
          addr_lo_d = axi_addr_i[1:0];
          funct3_d  = axi_funct3_i;
          rd_d      = addr_d_i;
          if (illegal) begin
            state_d   = S_DONE;
            err_d     = 1'b1;
            wb_we_d   = !axi_mem_we_i;
            wb_addr_d = addr_d_i;
            wb_data_d = '0;
          end else if (axi_mem_we_i) begin
            state_d   = S_WRITE;
            awaddr_d  = bus_addr;
            wdata_d   = lane_data;
            wstrb_d   = lane_strb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RADDR;
            araddr_d  = bus_addr;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
        // The valids themselves record which handshakes are still outstanding.
        awvalid_d = awvalid_q && !axi.m_axi_awready;
        wvalid_d  = wvalid_q && !axi.m_axi_wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = S_WRESP;
          bready_d = 1'b1;
        end
      end
      S_WRESP: begin
        if (axi.m_axi_bvalid) begin
          state_d  = S_DONE;
          bready_d = 1'b0;
          err_d    = (axi.m_axi_bresp != 2'b00);
        end
      end
      S_RADDR: begin
        if (axi.m_axi_arready) begin
          state_d   = S_RDATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      S_RDATA: begin
        if (axi.m_axi_rvalid) begin
          state_d   = S_DONE;
          rready_d  = 1'b0;
          err_d     = (axi.m_axi_rresp != 2'b00);
          wb_we_d   = 1'b1;
          wb_addr_d = rd_q;
          wb_data_d = (axi.m_axi_rresp != 2'b00) ? '0 : ld_ext;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      addr_lo_q <= '0;
      funct3_q  <= '0;
      rd_q      <= '0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      wb_we_q   <= 1'b0;
      err_q     <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_lo_q <= addr_lo_d;
      funct3_q  <= funct3_d;
      rd_q      <= rd_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      wb_we_q   <= wb_we_d;
      err_q     <= err_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign stall_o = ((state_q == S_IDLE) && axi_init_i) ||
                   ((state_q != S_IDLE) && (state_q != S_DONE));
  assign wb_we_o     = wb_we_q;
  assign wb_addr_d_o = wb_addr_q;
  assign wb_data_o   = wb_data_q;
  assign err_o       = err_q;

  assign axi.m_axi_awaddr  = awaddr_q;
  assign axi.m_axi_awprot  = 3'b000;
  assign axi.m_axi_awvalid = awvalid_q;
  assign axi.m_axi_wdata   = wdata_q;
  assign axi.m_axi_wstrb   = wstrb_q;
  assign axi.m_axi_wvalid  = wvalid_q;
  assign axi.m_axi_bready  = bready_q;
  assign axi.m_axi_araddr  = araddr_q;
  assign axi.m_axi_arprot  = 3'b000;
  assign axi.m_axi_arvalid = arvalid_q;
  assign axi.m_axi_rready  = rready_q;

endmodule
